// File: rtl/ht16d35a_command_sequencer.sv
// HT16D35A LED driver command sequencer: power-up wait, fixed init table, then
// brightness / display-RAM writes handed to an SPI controller via activate/busy.
module ht16d35a_command_sequencer #(
  parameter int                     NUM_SELECTS  = 2,
  parameter logic [NUM_SELECTS-1:0] CS_MASK      = NUM_SELECTS'(1),
  parameter int                     OUT_BYTES    = 8,
  parameter int                     OUT_BYTES_SZ = $clog2(OUT_BYTES + 1),
  parameter int                     IN_BYTES     = 4,
  parameter int                     IN_BYTES_SZ  = $clog2(IN_BYTES + 1),
  parameter int                     CLK_PWRUP    = 500000,
  parameter int                     ACK_TIMEOUT  = 1024,
  parameter logic [5:0]             BRIGHT_INIT  = 6'h20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_busy,
  output logic                         spi_activate,
  output logic [NUM_SELECTS-1:0]       spi_in_cs,
  output logic [OUT_BYTES-1:0][7:0]    spi_out_data,
  output logic [OUT_BYTES_SZ-1:0]      spi_out_count,
  output logic [IN_BYTES_SZ-1:0]       spi_in_count,
  input  logic                         bright_valid,
  input  logic [5:0]                   bright_value,
  input  logic                         ram_valid,
  input  logic [7:0]                   ram_addr,
  input  logic [3:0][7:0]              ram_data,
  output logic                         ready,
  output logic                         init_done,
  output logic                         err
);

  localparam int PWR_W = $clog2(CLK_PWRUP + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(CLK_PWRUP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

  state_t                      state_q;
  logic [PWR_W-1:0]            pwr_cnt_q;
  logic [TMO_W-1:0]            tmo_cnt_q;
  logic [1:0]                  init_idx_q;
  logic                        host_cmd_q;
  logic                        activate_q;
  logic [OUT_BYTES-1:0][7:0]   data_q;
  logic [OUT_BYTES_SZ-1:0]     count_q;
  logic                        ready_q;
  logic                        init_done_q;
  logic                        err_q;

  logic [OUT_BYTES-1:0][7:0]   init_data;
  logic [OUT_BYTES_SZ-1:0]     init_count;
  logic [OUT_BYTES-1:0][7:0]   bright_data;
  logic [OUT_BYTES-1:0][7:0]   ram_payload;

  always_comb begin
    init_data   = '0;
    init_count  = '0;
    bright_data = '0;
    ram_payload = '0;
    case (init_idx_q)
      2'd0: begin init_data[0] = 8'hCC; init_count = OUT_BYTES_SZ'(1); end
      2'd1: begin init_data[0] = 8'h32; init_data[1] = 8'h07; init_count = OUT_BYTES_SZ'(2); end
      2'd2: begin
        init_data[0] = 8'h37; init_data[1] = 8'h00; init_data[2] = {2'b00, BRIGHT_INIT};
        init_count = OUT_BYTES_SZ'(3);
      end
      default: begin init_data[0] = 8'h35; init_data[1] = 8'h03; init_count = OUT_BYTES_SZ'(2); end
    endcase
    bright_data[0] = 8'h37;
    bright_data[1] = 8'h00;
    bright_data[2] = {2'b00, bright_value};
    ram_payload[0] = 8'h80;
    ram_payload[1] = ram_addr;
    for (int i = 0; i < 4; i++) ram_payload[i+2] = ram_data[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PWRUP;
      pwr_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      init_idx_q  <= '0;
      host_cmd_q  <= 1'b0;
      activate_q  <= 1'b0;
      data_q      <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_PWRUP: begin
          if (pwr_cnt_q == PWR_LAST) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            host_cmd_q <= 1'b0;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + PWR_W'(1);
          end
        end
        // Shared launch point: holds off until the controller reports not-busy.
        S_INIT: begin
          if (!host_cmd_q) begin
            data_q  <= init_data;
            count_q <= init_count;
          end
          if (!spi_busy) begin
            activate_q <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_IDLE: begin
          if (ready_q && bright_valid) begin
            data_q     <= bright_data;
            count_q    <= OUT_BYTES_SZ'(3);
            host_cmd_q <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= S_INIT;
          end else if (ready_q && ram_valid) begin
            data_q     <= ram_payload;
            count_q    <= OUT_BYTES_SZ'(6);
            host_cmd_q <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= S_INIT;
          end
        end
        S_ISSUE: begin
          if (spi_busy) begin
            activate_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            activate_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= S_WAIT_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            if (host_cmd_q) begin
              host_cmd_q <= 1'b0;
              ready_q    <= 1'b1;
              state_q    <= S_IDLE;
            end else if (init_idx_q == 2'd3) begin
              init_done_q <= 1'b1;
              ready_q     <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              init_idx_q <= init_idx_q + 2'd1;
              state_q    <= S_INIT;
            end
          end
        end
        default: state_q <= S_PWRUP;
      endcase
    end
  end

  assign spi_activate  = activate_q;
  assign spi_in_cs     = CS_MASK;
  assign spi_out_data  = data_q;
  assign spi_out_count = count_q;
  assign spi_in_count  = '0;
  assign ready         = ready_q;
  assign init_done     = init_done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ht16d35a_command_sequencer.sv
// Randomised bench for the HT16D35A command sequencer with a behavioural SPI
// controller and a queue of expected transactions derived from the command set.
module tb_ht16d35a_command_sequencer;

  localparam int PWRUP = 40;
  localparam int TMO   = 32;
  localparam int OB    = 8;
  localparam int OBSZ  = $clog2(OB + 1);
  localparam int IBSZ  = $clog2(4 + 1);

  localparam int PH_BOOT = 0, PH_IDLE = 1, PH_ACK = 2, PH_BUSY = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  spi_busy = 1'b1;
  logic                  spi_activate;
  logic [1:0]            spi_in_cs;
  logic [OB-1:0][7:0]    spi_out_data;
  logic [OBSZ-1:0]       spi_out_count;
  logic [IBSZ-1:0]       spi_in_count;
  logic                  bright_valid = 1'b0;
  logic [5:0]            bright_value = '0;
  logic                  ram_valid = 1'b0;
  logic [7:0]            ram_addr = '0;
  logic [3:0][7:0]       ram_data = '0;
  logic                  ready, init_done, err;

  ht16d35a_command_sequencer #(
    .NUM_SELECTS(2), .CS_MASK(2'b01), .OUT_BYTES(OB), .IN_BYTES(4),
    .CLK_PWRUP(PWRUP), .ACK_TIMEOUT(TMO), .BRIGHT_INIT(6'h20)
  ) dut (
    .clk(clk), .reset(reset), .spi_busy(spi_busy), .spi_activate(spi_activate),
    .spi_in_cs(spi_in_cs), .spi_out_data(spi_out_data), .spi_out_count(spi_out_count),
    .spi_in_count(spi_in_count), .bright_valid(bright_valid), .bright_value(bright_value),
    .ram_valid(ram_valid), .ram_addr(ram_addr), .ram_data(ram_data),
    .ready(ready), .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  count;
  } txn_t;

  txn_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Controller model knobs and state
  int   acc_delay = 7;
  int   busy_len = 200;
  int   boot_len = 60;
  bit   never_busy = 1'b0;
  int   ph = PH_BOOT;
  int   acnt = 0, bcnt = 0, rel_cnt = 0, rx_since_rst = 0, rx_total = 0;
  bit   first_act = 1'b1;
  logic [63:0] snap_data;
  logic [3:0]  snap_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5);
    txn_t t;
    t.data  = {16'h0, b5, b4, b3, b2, b1, b0};
    t.count = 4'(n);
    return t;
  endfunction

  task automatic push_init();
    exp_q.push_back(mk(1, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(mk(2, 8'h32, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(mk(3, 8'h37, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(mk(2, 8'h35, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00));
  endtask

  // Behavioural SPI controller: busy during its own reset, accepts after
  // acc_delay, stays busy for busy_len.
  always @(negedge clk) begin
    if (reset) begin
      ph = PH_BOOT; spi_busy = 1'b1; bcnt = boot_len;
      rel_cnt = 0; first_act = 1'b1; rx_since_rst = 0;
    end else begin
      rel_cnt++;
      if (spi_activate && first_act) begin
        first_act = 1'b0;
        check_eq("pwrup_wait", 64'(rel_cnt > PWRUP), 1);
      end
      case (ph)
        PH_BOOT: begin
          check_eq("boot_no_act", spi_activate, 0);
          if (bcnt == 0) begin spi_busy = 1'b0; ph = PH_IDLE; end
          else bcnt--;
        end
        PH_IDLE: begin
          if (spi_activate && !never_busy) begin
            txn_t e;
            snap_data = spi_out_data;
            snap_cnt  = spi_out_count;
            rx_since_rst++; rx_total++;
            $display("txn %0d: count=%0d data=%h", rx_total, snap_cnt, snap_data);
            check_eq("txn_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check_eq("txn_data", snap_data, e.data);
              check_eq("txn_count", snap_cnt, e.count);
            end
            ph = PH_ACK; acnt = acc_delay;
          end
        end
        PH_ACK: begin
          check_eq("act_held", spi_activate, 1);
          check_eq("data_stable", spi_out_data, snap_data);
          check_eq("count_stable", spi_out_count, snap_cnt);
          if (acnt == 0) begin spi_busy = 1'b1; ph = PH_BUSY; bcnt = busy_len; end
          else acnt--;
        end
        default: begin
          check_eq("no_act_busy", spi_activate, 0);
          if (bcnt == 0) begin spi_busy = 1'b0; ph = PH_IDLE; end
          else bcnt--;
        end
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_act"},   spi_activate, 0);
    check_eq({tag, "_cs"},    spi_in_cs, 2'b01);
    check_eq({tag, "_data"},  spi_out_data, 0);
    check_eq({tag, "_cnt"},   spi_out_count, 0);
    check_eq({tag, "_incnt"}, spi_in_count, 0);
    check_eq({tag, "_ready"}, ready, 0);
    check_eq({tag, "_done"},  init_done, 0);
    check_eq({tag, "_err"},   err, 0);
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    @(negedge clk);
    while (!ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", ready, 1);
  endtask

  task automatic issue(input bit do_b, input logic [5:0] bv, input bit do_r,
                       input logic [7:0] ra, input logic [3:0][7:0] rd);
    int n = 0;
    @(negedge clk);
    bright_valid = do_b; bright_value = bv;
    ram_valid = do_r; ram_addr = ra; ram_data = rd;
    while ((bright_valid || ram_valid) && n < 3000) begin
      if (ready) begin
        if (bright_valid) begin
          if (!never_busy) exp_q.push_back(mk(3, 8'h37, 8'h00, {2'b00, bv}, 8'h00, 8'h00, 8'h00));
          @(negedge clk);
          bright_valid = 1'b0;
        end else begin
          if (!never_busy) exp_q.push_back(mk(6, 8'h80, ra, rd[0], rd[1], rd[2], rd[3]));
          @(negedge clk);
          ram_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("req_accept", 64'(bright_valid | ram_valid), 0);
    bright_valid = 1'b0;
    ram_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int act_len;
    logic [3:0][7:0] rd;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    push_init();
    @(negedge clk);
    #2 reset = 1'b0;

    // Power-up + init with 7-cycle acceptance, 200-cycle busy
    wait_ready(4000);
    check_eq("init_done", init_done, 1);
    check_eq("init_err", err, 0);
    check_eq("init_all_sent", exp_q.size(), 0);

    // Simultaneous requests: brightness first, RAM stays pending
    rd = {8'h04, 8'h03, 8'h02, 8'h01};
    issue(1'b1, 6'h3F, 1'b1, 8'h10, rd);
    wait_ready(2000);
    check_eq("pair_sent", exp_q.size(), 0);

    for (int i = 0; i < 15; i++) begin
      acc_delay = $urandom_range(0, 10);
      busy_len  = $urandom_range(1, 30);
      rd = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      case ($urandom_range(0, 2))
        0: issue(1'b1, 6'($urandom), 1'b0, 8'h00, rd);
        1: issue(1'b0, 6'h00, 1'b1, 8'($urandom), rd);
        default: issue(1'b1, 6'($urandom), 1'b1, 8'($urandom), rd);
      endcase
      wait_ready(2000);
    end
    check_eq("rand_all_sent", exp_q.size(), 0);
    check_eq("rand_err", err, 0);

    // Acceptance timeout: activate held exactly ACK_TIMEOUT cycles
    never_busy = 1'b1;
    issue(1'b1, 6'h2A, 1'b0, 8'h00, rd);
    n = 0;
    while (!spi_activate && n < 100) begin @(negedge clk); n++; end
    act_len = 0;
    while (spi_activate && act_len < 500) begin @(negedge clk); act_len++; end
    check_eq("tmo_len", act_len, TMO);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_act", spi_activate, 0);
    wait_ready(200);
    never_busy = 1'b0;
    acc_delay = 3; busy_len = 10;
    issue(1'b0, 6'h00, 1'b1, 8'h55, rd);
    wait_ready(500);
    check_eq("tmo_err_sticky", err, 1);
    check_eq("post_tmo_sent", exp_q.size(), 0);

    // Reset during the third init transaction
    boot_len = 5; acc_delay = 3; busy_len = 20;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    push_init();
    @(negedge clk);
    #2 reset = 1'b0;
    n = 0;
    while (!(rx_since_rst == 3 && ph == PH_BUSY) && n < 3000) begin @(negedge clk); n++; end
    check_eq("third_txn_reached", rx_since_rst, 3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    exp_q.delete();
    push_init();
    @(negedge clk);
    #2 reset = 1'b0;
    wait_ready(4000);
    check_eq("restart_done", init_done, 1);
    check_eq("restart_err", err, 0);
    check_eq("restart_all_sent", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
